hls_chain_sequencer: RTL and testbench

- Parametrised sequencer for a linear chain of NSTAGES HLS processes joined by BX-paged memories.
- Replaces the hard-wired done-to-start chaining of the three-stage chain with fully clocked ap_start/ap_ready/ap_done handshakes.
- Adds per-stage BX tagging for memory page selection, single-slot pending buffers between stages, sticky overrun detection, and a completed-event counter.
- Sits at the top level between the external event source and the process instances.

---
 rtl/hls_chain_sequencer.sv | 123 ++++++++++++
 tb/tb_hls_chain_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_chain_sequencer.sv
// Clocked ap_start/ap_ready/ap_done sequencer for a linear chain of HLS processes,
// carrying a BX tag per stage for page selection of the inter-stage memories.
module hls_chain_sequencer #(
  parameter int NSTAGES = 3,
  parameter int BX_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_proc,
  input  logic [BX_W-1:0]         bx_in,
  output logic                    in_ready,
  output logic [NSTAGES-1:0]      stage_start,
  input  logic [NSTAGES-1:0]      stage_ready,
  input  logic [NSTAGES-1:0]      stage_done,
  output logic [NSTAGES*BX_W-1:0] stage_bx,
  output logic [NSTAGES-1:0]      stage_busy,
  output logic [BX_W-1:0]         bx_out,
  output logic                    bx_valid,
  output logic [CNT_W-1:0]        evt_count,
  output logic [NSTAGES-1:0]      overrun,
  input  logic                    clear_err
);

  // Handshake: a stage owns an event from launch (start) until ap_done is seen
  // while owning; ap_ready only moves it from start to busy. A pending slot
  // accepts an arrival when empty or when it launches in the same cycle.
  logic [NSTAGES-1:0] r_pend;
  logic [NSTAGES-1:0] r_start;
  logic [NSTAGES-1:0] r_busy;
  logic [NSTAGES-1:0] r_ovr;
  logic [BX_W-1:0]    r_pbx [NSTAGES];
  logic [BX_W-1:0]    r_sbx [NSTAGES];
  logic [BX_W-1:0]    r_bx_out;
  logic               r_bx_valid;
  logic [CNT_W-1:0]   r_cnt;

  logic [NSTAGES-1:0] w_own;
  logic [NSTAGES-1:0] w_launch;
  logic [NSTAGES-1:0] w_done;
  logic [NSTAGES-1:0] w_arr;
  logic [NSTAGES-1:0] w_acc;
  logic [NSTAGES-1:0] w_ovr_set;
  logic [BX_W-1:0]    w_arr_bx [NSTAGES];

  always_comb begin
    w_own    = r_start | r_busy;
    w_launch = r_pend & ~w_own;
    w_done   = stage_done & w_own;
    w_arr    = '0;
    w_acc    = '0;
    for (int i = 0; i < NSTAGES; i++) begin
      w_arr_bx[i] = '0;
    end
    // Stage 0 only accepts when its slot is already empty (in_ready).
    w_arr[0]    = en_proc;
    w_arr_bx[0] = bx_in;
    w_acc[0]    = en_proc & ~r_pend[0];
    for (int i = 1; i < NSTAGES; i++) begin
      w_arr[i]    = w_done[i-1];
      w_arr_bx[i] = r_sbx[i-1];
      w_acc[i]    = w_done[i-1] & (~r_pend[i] | w_launch[i]);
    end
    w_ovr_set = w_arr & ~w_acc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend     <= '0;
      r_start    <= '0;
      r_busy     <= '0;
      r_ovr      <= '0;
      r_bx_out   <= '0;
      r_bx_valid <= 1'b0;
      r_cnt      <= '0;
      for (int i = 0; i < NSTAGES; i++) begin
        r_pbx[i] <= '0;
        r_sbx[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NSTAGES; i++) begin
        if (w_launch[i]) begin
          r_start[i] <= 1'b1;
          r_sbx[i]   <= r_pbx[i];
        end else if (w_done[i]) begin
          r_start[i] <= 1'b0;
          r_busy[i]  <= 1'b0;
        end else if (r_start[i] && stage_ready[i]) begin
          r_start[i] <= 1'b0;
          r_busy[i]  <= 1'b1;
        end

        if (w_acc[i]) begin
          r_pend[i] <= 1'b1;
          r_pbx[i]  <= w_arr_bx[i];
        end else if (w_launch[i]) begin
          r_pend[i] <= 1'b0;
        end
      end

      // A new drop in the same cycle as clear_err still gets recorded.
      r_ovr      <= (clear_err ? '0 : r_ovr) | w_ovr_set;
      r_bx_valid <= w_done[NSTAGES-1];
      if (w_done[NSTAGES-1]) begin
        r_bx_out <= r_sbx[NSTAGES-1];
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  assign in_ready    = ~r_pend[0];
  assign stage_start = r_start;
  assign stage_busy  = w_own;
  assign bx_out      = r_bx_out;
  assign bx_valid    = r_bx_valid;
  assign evt_count   = r_cnt;
  assign overrun     = r_ovr;

  for (genvar g = 0; g < NSTAGES; g++) begin : g_bx
    assign stage_bx[g*BX_W +: BX_W] = r_sbx[g];
  end

endmodule

// File: tb/tb_hls_chain_sequencer.sv
// Bench for hls_chain_sequencer: cycle table for a single event through three
// stages, then directed sequences for overrun, stall, spurious done, reset and wrap.
module tb_hls_chain_sequencer;

  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en_proc = 1'b0;
  logic [1:0]    bx_in = '0;
  logic          in_ready;
  logic [NS-1:0] stage_start;
  logic [NS-1:0] stage_ready;
  logic [NS-1:0] stage_done;
  logic [5:0]    stage_bx;
  logic [NS-1:0] stage_busy;
  logic [1:0]    bx_out;
  logic          bx_valid;
  logic [15:0]   evt_count;
  logic [NS-1:0] overrun;
  logic          clear_err = 1'b0;

  logic [NS-1:0] rsp_ready = '0, rsp_done = '0;
  logic [NS-1:0] tbl_ready = '0, tbl_done = '0, spur_done = '0;
  assign stage_ready = rsp_ready | tbl_ready;
  assign stage_done  = rsp_done | tbl_done | spur_done;

  // single-stage instance with a 2-bit counter
  logic       s_en = 1'b0, s_rdy = 1'b0, s_dn = 1'b0, s_clr = 1'b0;
  logic [1:0] s_bx = '0;
  logic       s_inr, s_start, s_busy, s_bxv, s_ovr;
  logic [1:0] s_sbx, s_bxo, s_cnt;

  hls_chain_sequencer #(.NSTAGES(NS), .BX_W(2), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .en_proc(en_proc), .bx_in(bx_in), .in_ready(in_ready),
    .stage_start(stage_start), .stage_ready(stage_ready), .stage_done(stage_done),
    .stage_bx(stage_bx), .stage_busy(stage_busy), .bx_out(bx_out), .bx_valid(bx_valid),
    .evt_count(evt_count), .overrun(overrun), .clear_err(clear_err)
  );

  hls_chain_sequencer #(.NSTAGES(1), .BX_W(2), .CNT_W(2)) u_small (
    .clk(clk), .reset(reset), .en_proc(s_en), .bx_in(s_bx), .in_ready(s_inr),
    .stage_start(s_start), .stage_ready(s_rdy), .stage_done(s_dn),
    .stage_bx(s_sbx), .stage_busy(s_busy), .bx_out(s_bxo), .bx_valid(s_bxv),
    .evt_count(s_cnt), .overrun(s_ovr), .clear_err(s_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stage responder: ready after rd_dly steps, done dn_dly steps after ready.
  bit resp_on = 1'b0;
  int rd_dly[NS];
  int dn_dly[NS];
  bit stall[NS];
  int ph[NS];
  int cnt[NS];

  initial begin
    for (int i = 0; i < NS; i++) begin
      ph[i] = 0; cnt[i] = 0; rd_dly[i] = 1; dn_dly[i] = 0; stall[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = '0;
      rsp_done  = '0;
      for (int i = 0; i < NS; i++) begin
        if (!reset || !resp_on) begin
          ph[i] = 0;
        end else if (ph[i] == 0) begin
          if (stage_start[i]) begin
            ph[i]  = 1;
            cnt[i] = rd_dly[i];
          end
        end else if (ph[i] == 1) begin
          if (cnt[i] > 0) cnt[i]--;
          if (cnt[i] == 0 && !stall[i]) begin
            rsp_ready[i] = 1'b1;
            if (dn_dly[i] == 0) begin
              rsp_done[i] = 1'b1;
              ph[i] = 0;
            end else begin
              ph[i]  = 2;
              cnt[i] = dn_dly[i];
            end
          end
        end else begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            rsp_done[i] = 1'b1;
            ph[i] = 0;
          end
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    en_proc = 1'b0;
    clear_err = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
  endtask

  task automatic send(input logic [1:0] bx, input int gap);
    en_proc = 1'b1;
    bx_in   = bx;
    step();
    en_proc = 1'b0;
    repeat (gap) step();
  endtask

  task automatic wait_valid(input string name, input logic [1:0] exp_bx);
    int n = 0;
    do begin
      step();
      n++;
    end while (!bx_valid && n < 200);
    if (!bx_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: bx_valid never seen within 200 cycles", name);
    end else begin
      chk(name, bx_out, exp_bx);
    end
  endtask

  task automatic small_event(input logic [1:0] bx, input logic dbl, input logic [1:0] exp_cnt);
    s_en = 1'b1;
    s_bx = bx;
    step();
    s_en = dbl;
    step();
    s_en = 1'b0;
    chk("t6_start", s_start, 1'b1);
    s_rdy = 1'b1;
    s_dn  = 1'b1;
    step();
    s_rdy = 1'b0;
    s_dn  = 1'b0;
    chk("t6_bxv", s_bxv, 1'b1);
    chk("t6_bxo", s_bxo, bx);
    chk("t6_cnt", s_cnt, exp_cnt);
    step();
    chk("t6_bxv_low", s_bxv, 1'b0);
  endtask

  typedef struct {
    logic        en;
    logic [1:0]  bx;
    logic [2:0]  rdy;
    logic [2:0]  dn;
    logic [2:0]  e_own;
    logic [5:0]  e_sbx;
    logic        e_inr;
    logic        e_bxv;
    logic [1:0]  e_bxo;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(logic en, logic [1:0] bx, logic [2:0] rdy, logic [2:0] dn,
                              logic [2:0] own, logic [5:0] sbx, logic inr, logic bxv,
                              logic [1:0] bxo, logic [15:0] c);
    vec_t v;
    v.en = en; v.bx = bx; v.rdy = rdy; v.dn = dn; v.e_own = own; v.e_sbx = sbx;
    v.e_inr = inr; v.e_bxv = bxv; v.e_bxo = bxo; v.e_cnt = c;
    return v;
  endfunction

  vec_t tbl[$];
  int exp_seq[5] = '{1, 2, 3, 0, 1};

  initial begin
    // row k: inputs during cycle k, expected state during cycle k+1
    tbl.push_back(mk(1, 2, 3'b000, 3'b000, 3'b000, 6'b000000, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 0, 3'b000, 3'b000, 3'b001, 6'b000010, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'b001, 3'b001, 3'b000, 6'b000010, 1, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 0, 3'b000, 3'b000, 3'b010, 6'b001010, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'b010, 3'b010, 3'b000, 6'b001010, 1, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 0, 3'b000, 3'b000, 3'b100, 6'b101010, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'b100, 3'b100, 3'b000, 6'b101010, 1, 1, 2, 1));
    tbl.push_back(mk(0, 0, 3'b000, 3'b000, 3'b000, 6'b101010, 1, 0, 2, 1));

    // reset state
    reset = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_start", stage_start, 3'b000);
    chk("rst_busy", stage_busy, 3'b000);
    chk("rst_stage_bx", stage_bx, 6'b0);
    chk("rst_bx_valid", bx_valid, 1'b0);
    chk("rst_evt_count", evt_count, 16'd0);
    chk("rst_overrun", overrun, 3'b000);
    do_reset();

    // test 1: single event, cycle-exact
    for (int k = 0; k < tbl.size(); k++) begin
      en_proc   = tbl[k].en;
      bx_in     = tbl[k].bx;
      tbl_ready = tbl[k].rdy;
      tbl_done  = tbl[k].dn;
      step();
      chk($sformatf("t1_start_r%0d", k), stage_start, tbl[k].e_own);
      chk($sformatf("t1_busy_r%0d", k), stage_busy, tbl[k].e_own);
      chk($sformatf("t1_bx_r%0d", k), stage_bx, tbl[k].e_sbx);
      chk($sformatf("t1_inr_r%0d", k), in_ready, tbl[k].e_inr);
      chk($sformatf("t1_bxv_r%0d", k), bx_valid, tbl[k].e_bxv);
      chk($sformatf("t1_bxo_r%0d", k), bx_out, tbl[k].e_bxo);
      chk($sformatf("t1_cnt_r%0d", k), evt_count, tbl[k].e_cnt);
      chk($sformatf("t1_ovr_r%0d", k), overrun, 3'b000);
    end
    en_proc = 1'b0; tbl_ready = '0; tbl_done = '0;

    // test 2: back-to-back events into a slow stage 0
    do_reset();
    resp_on = 1'b1;
    rd_dly = '{3, 3, 3};
    dn_dly = '{10, 0, 0};
    for (int k = 0; k < 8; k++) begin
      en_proc = (k % 2 == 0);
      bx_in   = 2'(k / 2);
      step();
    end
    en_proc = 1'b0;
    chk("t2_overrun", overrun, 3'b001);
    chk("t2_in_ready", in_ready, 1'b0);
    chk("t2_bx0_owned", stage_bx[1:0], 2'd0);
    chk("t2_busy0", stage_busy[0], 1'b1);
    wait_valid("t2_first_bx", 2'd0);
    wait_valid("t2_second_bx", 2'd1);
    chk("t2_cnt", evt_count, 16'd2);
    repeat (40) step();
    chk("t2_cnt_final", evt_count, 16'd2);
    chk("t2_overrun_final", overrun, 3'b001);

    // test 3: stage 1 stalled while stage 0 keeps completing
    do_reset();
    rd_dly = '{1, 1, 1};
    dn_dly = '{0, 0, 0};
    stall[1] = 1'b1;
    send(2'd1, 9);
    chk("t3_start1", stage_start, 3'b010);
    chk("t3_bx1_a", stage_bx[3:2], 2'd1);
    send(2'd2, 9);
    chk("t3_no_ovr_pend", overrun, 3'b000);
    chk("t3_busy", stage_busy, 3'b010);
    send(2'd3, 9);
    chk("t3_overrun", overrun, 3'b010);
    chk("t3_start1_held", stage_start[1], 1'b1);
    chk("t3_bx1_kept", stage_bx[3:2], 2'd1);
    chk("t3_cnt0", evt_count, 16'd0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("t3_cleared", overrun, 3'b000);
    stall[1] = 1'b0;
    wait_valid("t3_first_bx", 2'd1);
    wait_valid("t3_second_bx", 2'd2);
    repeat (30) step();
    chk("t3_cnt", evt_count, 16'd2);
    chk("t3_idle", stage_busy, 3'b000);

    // test 4: spurious done while idle
    spur_done = 3'b111;
    step();
    spur_done = '0;
    chk("t4_bxv", bx_valid, 1'b0);
    chk("t4_cnt", evt_count, 16'd2);
    chk("t4_busy", stage_busy, 3'b000);
    step();
    chk("t4_bxv_next", bx_valid, 1'b0);
    chk("t4_cnt_next", evt_count, 16'd2);

    // test 5: asynchronous reset with stages 0 and 1 owning events
    stall[1] = 1'b1;
    send(2'd1, 9);
    stall[0] = 1'b1;
    send(2'd2, 5);
    chk("t5_busy", stage_busy, 3'b011);
    en_proc = 1'b1;
    bx_in   = 2'd3;
    repeat (2) step();
    en_proc = 1'b0;
    chk("t5_pre_ovr", overrun, 3'b001);
    chk("t5_pre_inr", in_ready, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("t5_start", stage_start, 3'b000);
    chk("t5_busy0", stage_busy, 3'b000);
    chk("t5_stage_bx", stage_bx, 6'b0);
    chk("t5_bx_out", bx_out, 2'd0);
    chk("t5_bxv", bx_valid, 1'b0);
    chk("t5_cnt", evt_count, 16'd0);
    chk("t5_ovr", overrun, 3'b000);
    chk("t5_inr", in_ready, 1'b1);
    step();
    reset = 1'b1;
    stall[0] = 1'b0;
    stall[1] = 1'b0;
    repeat (2) step();
    send(2'd2, 0);
    wait_valid("t5_fresh_bx", 2'd2);
    chk("t5_fresh_cnt", evt_count, 16'd1);

    // test 6: single stage, 2-bit counter wrap, clear behaviour
    resp_on = 1'b0;
    for (int e = 0; e < 5; e++) begin
      small_event(2'(e), (e == 0), 2'(exp_seq[e]));
    end
    chk("t6_ovr_sticky", s_ovr, 1'b1);
    s_clr = 1'b1;
    step();
    s_clr = 1'b0;
    chk("t6_ovr_clr", s_ovr, 1'b0);
    step();
    chk("t6_ovr_stays0", s_ovr, 1'b0);
    s_en = 1'b1;
    s_bx = 2'd3;
    step();
    s_clr = 1'b1;
    step();
    s_en  = 1'b0;
    s_clr = 1'b0;
    chk("t6_set_beats_clr", s_ovr, 1'b1);
    s_rdy = 1'b1;
    s_dn  = 1'b1;
    step();
    s_rdy = 1'b0;
    s_dn  = 1'b0;
    chk("t6_last_cnt", s_cnt, 2'd2);
    chk("t6_last_bxo", s_bxo, 2'd3);
    s_clr = 1'b1;
    step();
    s_clr = 1'b0;
    chk("t6_final_clr", s_ovr, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
